subleq_core_p: RTL and testbench

SUBLEQ_CORE_P -- requirements
Module: subleq_core_p

---
 rtl/subleq_core_p.sv | 236 +++++++++++++++++++++++
 tb/tb_subleq_core_p.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_core_p.sv
// SUBLEQ processor core: mem[A] -= mem[B]; branch to C when the result is <= 0.
// One request/acknowledge memory port shared by instruction fetch, operand access and the loader.
module subleq_core_p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              load_wr,
  input  logic              load_pc,
  input  logic [DATA_W-1:0] load_data,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  icount
);

  typedef enum logic [2:0] {
    StHalt,
    StFetchA,
    StFetchB,
    StFetchC,
    StLoadA,
    StLoadB,
    StStore,
    StNext
  } state_e;

  // Highest PC from which a full three-word instruction can be fetched.
  localparam logic [ADDR_W-1:0] MaxPc = {ADDR_W{1'b1}} - ADDR_W'(2);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   c_q, c_d;
  logic [DATA_W-1:0]   ma_q, ma_d;
  logic [DATA_W-1:0]   mb_q, mb_d;
  logic [DATA_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0]    icount_q, icount_d;
  logic                bp_hit_q, bp_hit_d;
  logic                step_mode_q, step_mode_d;
  logic                run_q;
  logic                step_q;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                run_rise;
  logic                step_rise;
  logic                r_le_zero;
  logic [ADDR_W-1:0]   next_pc;
  logic                bp_match;
  logic                keep_running;

  assign run_rise     = run & ~run_q;
  assign step_rise    = step & ~step_q;
  assign r_le_zero    = (r_q == '0) | r_q[DATA_W-1];
  assign next_pc      = r_le_zero ? c_q[ADDR_W-1:0] : pc_q + ADDR_W'(3);
  assign bp_match     = bp_en & (next_pc == bp_addr);
  // Free-running continuation is only possible in run mode with a fetchable next PC.
  assign keep_running = run & ~step_mode_q & (next_pc <= MaxPc);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    r_d         = r_q;
    icount_d    = icount_q;
    bp_hit_d    = bp_hit_q;
    step_mode_d = step_mode_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StHalt: begin
        if (mem_req_q) begin
          // Loader write outstanding: everything else waits for the ack.
          if (mem_ack) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            pc_d      = pc_q + ADDR_W'(1);
          end
        end else if (load_pc) begin
          pc_d = load_data[ADDR_W-1:0];
        end else if (load_wr) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = pc_q;
          mem_wdata_d = load_data;
        end else if ((run_rise | step_rise) && (pc_q <= MaxPc)) begin
          state_d     = StFetchA;
          step_mode_d = step_rise;
          bp_hit_d    = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = pc_q;
        end
      end
      StFetchA: begin
        if (mem_ack) begin
          a_d        = mem_rdata;
          mem_addr_d = pc_q + ADDR_W'(1);
          state_d    = StFetchB;
        end
      end
      StFetchB: begin
        if (mem_ack) begin
          b_d        = mem_rdata;
          mem_addr_d = pc_q + ADDR_W'(2);
          state_d    = StFetchC;
        end
      end
      StFetchC: begin
        if (mem_ack) begin
          c_d        = mem_rdata;
          mem_addr_d = a_q[ADDR_W-1:0];
          state_d    = StLoadA;
        end
      end
      StLoadA: begin
        if (mem_ack) begin
          ma_d       = mem_rdata;
          mem_addr_d = b_q[ADDR_W-1:0];
          state_d    = StLoadB;
        end
      end
      StLoadB: begin
        if (mem_ack) begin
          mb_d        = mem_rdata;
          r_d         = ma_q - mem_rdata;
          mem_we_d    = 1'b1;
          mem_addr_d  = a_q[ADDR_W-1:0];
          mem_wdata_d = ma_q - mem_rdata;
          state_d     = StStore;
        end
      end
      StStore: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StNext;
        end
      end
      StNext: begin
        pc_d     = next_pc;
        icount_d = icount_q + CNT_W'(1);
        if (keep_running && !bp_match) begin
          state_d    = StFetchA;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = next_pc;
        end else begin
          state_d = StHalt;
          // Only a breakpoint that actually caused the stop is reported.
          if (keep_running) begin
            bp_hit_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = StHalt;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHalt;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      r_q         <= '0;
      icount_q    <= '0;
      bp_hit_q    <= 1'b0;
      step_mode_q <= 1'b0;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      r_q         <= r_d;
      icount_q    <= icount_d;
      bp_hit_q    <= bp_hit_d;
      step_mode_q <= step_mode_d;
      run_q       <= run;
      step_q      <= step;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = (state_q == StHalt);
  assign pc        = pc_q;
  assign bp_hit    = bp_hit_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_subleq_core_p.sv
// Directed bench for subleq_core_p: behavioural memory with optional random ack delay,
// hand-computed expectations for loader, step, run, branch, breakpoint and reset cases.
module tb_subleq_core_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        load_wr = 1'b0;
  logic        load_pc = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'h00;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        halted;
  logic [7:0]  pc;
  logic        bp_hit;
  logic [15:0] icount;

  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        zero_wait = 1'b1;
  int unsigned wait_cnt = 0;
  logic        bd_we = 1'b0;
  logic        bd_clr = 1'b0;
  logic [7:0]  bd_addr = 8'h00;
  logic [7:0]  bd_data = 8'h00;
  int          tests = 0;
  int          fails = 0;

  subleq_core_p #(.DATA_W(8), .ADDR_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .load_wr   (load_wr),
    .load_pc   (load_pc),
    .load_data (load_data),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .halted    (halted),
    .pc        (pc),
    .bp_hit    (bp_hit),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  assign mem_ack   = zero_wait ? 1'b1 : (mem_req && wait_cnt == 0);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_req && mem_ack) wait_cnt <= $urandom_range(0, 3);
    else if (mem_req && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
  end

  // An unacknowledged request must be held unchanged into the next cycle.
  logic       prev_pend = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic       prev_we = 1'b0;
  always @(negedge clk) begin
    if (prev_pend) begin
      tests++;
      assert (mem_req === 1'b1 && mem_addr === prev_addr && mem_we === prev_we) else begin
        fails++;
        $error("FAIL req_stable: observed req=%0b addr=%0h we=%0b expected req=1 addr=%0h we=%0b",
               mem_req, mem_addr, mem_we, prev_addr, prev_we);
      end
    end
    prev_pend = mem_req && !mem_ack && !rst;
    prev_addr = mem_addr;
    prev_we   = mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic clear_mem();
    bd_clr = 1'b1;
    tick();
    bd_clr = 1'b0;
  endtask

  task automatic set_pc(input logic [7:0] a);
    load_pc = 1'b1; load_data = a;
    tick();
    load_pc = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] d);
    int n;
    load_wr = 1'b1; load_data = d;
    tick();
    load_wr = 1'b0;
    n = 0;
    while (mem_req && n < 20) begin
      tick();
      n++;
    end
    check("load_ack_timeout", 32'(mem_req), 32'd0);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      tick();
      cyc++;
    end
    check("halt_timeout", 32'(halted), 32'd1);
  endtask

  // Countdown loop: mem[30] 5->0, then branch off the end to 254; 10 instructions total.
  task automatic init_loop();
    clear_mem();
    poke(8'd0, 8'd30); poke(8'd1, 8'd31); poke(8'd2, 8'd6);
    poke(8'd3, 8'd32); poke(8'd4, 8'd32); poke(8'd5, 8'd0);
    poke(8'd6, 8'd32); poke(8'd7, 8'd32); poke(8'd8, 8'd254);
    poke(8'd30, 8'd5); poke(8'd31, 8'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int diffs;
    logic [15:0] ic0;

    clear_mem();
    tick();
    rst = 1'b0;
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_icount", 32'(icount), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Loader + single step: 1 - 3 = 0xFE (negative) -> branch to 20.
    set_pc(8'd0);
    load_word(8'd10); load_word(8'd11); load_word(8'd20);
    check("load_pc_inc", 32'(pc), 32'd3);
    check("load_mem2", 32'(mem[2]), 32'd20);
    set_pc(8'd10);
    load_word(8'd1); load_word(8'd3);
    check("load_mem11", 32'(mem[11]), 32'd3);
    set_pc(8'd0);
    pulse_step();
    wait_halt(50, cyc);
    check("step_cycles", 32'(cyc), 32'd7);
    check("step_mem10", 32'(mem[10]), 32'hFE);
    check("step_pc", 32'(pc), 32'd20);
    check("step_icount", 32'(icount), 32'd1);

    // 1 - 0 = 1 (positive) -> fall through to 3.
    poke(8'd10, 8'd1); poke(8'd11, 8'd0);
    set_pc(8'd0);
    pulse_step();
    wait_halt(50, cyc);
    check("nobr_mem10", 32'(mem[10]), 32'd1);
    check("nobr_pc", 32'(pc), 32'd3);
    check("nobr_icount", 32'(icount), 32'd2);

    // {3,3,0} with mem[3]=5: clears mem[3], loops at 0 every 7 cycles.
    clear_mem();
    poke(8'd0, 8'd3); poke(8'd1, 8'd3); poke(8'd2, 8'd0); poke(8'd3, 8'd5);
    set_pc(8'd0);
    run = 1'b1;
    tick();
    repeat (7) tick();
    check("loop_mem3", 32'(mem[3]), 32'd0);
    check("loop_pc", 32'(pc), 32'd0);
    check("loop_icount1", 32'(icount), 32'd3);
    check("loop_running", 32'(halted), 32'd0);
    repeat (7) tick();
    check("loop_icount2", 32'(icount), 32'd4);
    run = 1'b0;
    wait_halt(50, cyc);
    check("stop_icount", 32'(icount), 32'd5);
    check("stop_pc", 32'(pc), 32'd0);
    check("stop_bp_hit", 32'(bp_hit), 32'd0);

    // Branch to 254 (> MAXPC) halts without bp_hit; a new run edge cannot start there.
    clear_mem();
    poke(8'd0, 8'd20); poke(8'd1, 8'd20); poke(8'd2, 8'd254); poke(8'd20, 8'd7);
    set_pc(8'd0);
    run = 1'b1;
    tick();
    wait_halt(50, cyc);
    check("oob_pc", 32'(pc), 32'd254);
    check("oob_bp_hit", 32'(bp_hit), 32'd0);
    run = 1'b0; tick();
    run = 1'b1; tick(); tick();
    check("oob_still_halted", 32'(halted), 32'd1);
    check("oob_no_req", 32'(mem_req), 32'd0);
    check("oob_icount", 32'(icount), 32'd6);
    run = 1'b0; tick();

    // Breakpoint at 3: {20,21,0} falls through, {22,22,0} jumps back to 0.
    clear_mem();
    poke(8'd0, 8'd20); poke(8'd1, 8'd21); poke(8'd2, 8'd0);
    poke(8'd3, 8'd22); poke(8'd4, 8'd22); poke(8'd5, 8'd0);
    poke(8'd20, 8'd5); poke(8'd21, 8'd1); poke(8'd22, 8'd9);
    bp_en = 1'b1; bp_addr = 8'd3;
    set_pc(8'd0);
    run = 1'b1;
    tick();
    wait_halt(50, cyc);
    check("bp_pc", 32'(pc), 32'd3);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_icount", 32'(icount), 32'd7);
    check("bp_mem20", 32'(mem[20]), 32'd4);
    run = 1'b0; tick();
    run = 1'b1; tick();
    check("bp_resume_running", 32'(halted), 32'd0);
    check("bp_hit_cleared", 32'(bp_hit), 32'd0);
    wait_halt(100, cyc);
    check("bp2_pc", 32'(pc), 32'd3);
    check("bp2_hit", 32'(bp_hit), 32'd1);
    check("bp2_icount", 32'(icount), 32'd9);
    check("bp2_mem20", 32'(mem[20]), 32'd3);
    check("bp2_mem22", 32'(mem[22]), 32'd0);
    run = 1'b0; bp_en = 1'b0; tick();

    // Self-modifying: instruction at 0 rewrites its own C; third step must branch to new C=20.
    clear_mem();
    poke(8'd0, 8'd2); poke(8'd1, 8'd34); poke(8'd2, 8'd40);
    poke(8'd3, 8'd35); poke(8'd4, 8'd35); poke(8'd5, 8'd0);
    poke(8'd34, 8'd20);
    set_pc(8'd0);
    pulse_step(); wait_halt(50, cyc);
    check("smc_mem2", 32'(mem[2]), 32'd20);
    check("smc_step_clears_bp", 32'(bp_hit), 32'd0);
    pulse_step(); wait_halt(50, cyc);
    pulse_step(); wait_halt(50, cyc);
    check("smc_pc", 32'(pc), 32'd20);
    check("smc_mem2_final", 32'(mem[2]), 32'd0);
    check("smc_icount", 32'(icount), 32'd12);

    // Same program with zero-wait and random-wait memory must give identical results.
    zero_wait = 1'b1;
    init_loop();
    set_pc(8'd0);
    ic0 = icount;
    run = 1'b1; tick();
    wait_halt(2000, cyc);
    run = 1'b0; tick();
    check("zw_pc", 32'(pc), 32'd254);
    check("zw_mem30", 32'(mem[30]), 32'd0);
    check("zw_icount", 32'(icount - ic0), 32'd10);
    for (int i = 0; i < 256; i++) img[i] = mem[i];

    zero_wait = 1'b0;
    init_loop();
    set_pc(8'd0);
    ic0 = icount;
    run = 1'b1; tick();
    wait_halt(2000, cyc);
    run = 1'b0; tick();
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) diffs++;
    check("rw_image_diffs", 32'(diffs), 32'd0);
    check("rw_icount", 32'(icount - ic0), 32'd10);
    check("rw_pc", 32'(pc), 32'd254);

    // Reset in the middle of FETCH_B abandons the request at once.
    zero_wait = 1'b1;
    set_pc(8'd5);
    pulse_step();
    tick();
    check("fb_req", 32'(mem_req), 32'd1);
    check("fb_addr", 32'(mem_addr), 32'd6);
    rst = 1'b1;
    tick();
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd1);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_icount", 32'(icount), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
